param_datapath: RTL and testbench

Parametrised single-bus datapath: configurable GPR file, special registers (PC, IR, Y, Z_HI/Z_LO, HI, LO, MAR, MDR), and a one-hot-select shared bus with priority resolution and a sticky contention flag. Its ALU is single-cycle for logic and add-class operations. MUL and DIV are iterative behind a start/busy/done handshake and write Z without further control.

---
 rtl/dp_pkg.sv | 37 +++
 rtl/param_datapath_if.sv | 35 +++
 rtl/param_datapath_alu_iter.sv | 128 ++++++++++++
 rtl/param_datapath.sv | 149 ++++++++++++++
 tb/tb_param_datapath.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared opcodes, special-register bus select indices and the iterative ALU
// state encoding for the param_datapath slice.
package dp_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  localparam int unsigned SPC_PC   = 0;
  localparam int unsigned SPC_HI   = 1;
  localparam int unsigned SPC_LO   = 2;
  localparam int unsigned SPC_ZHI  = 3;
  localparam int unsigned SPC_ZLO  = 4;
  localparam int unsigned SPC_MDR  = 5;
  localparam int unsigned SPC_IN   = 6;
  localparam int unsigned SPC_CIMM = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_t;

  function automatic logic is_iter_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/param_datapath_if.sv
// Control, source and observation signals of the datapath grouped as one bundle;
// the controller side is master, the datapath side is slave.
interface param_datapath_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 16
);
  logic [NUM_GPR-1:0]         gpr_wen;
  logic [NUM_GPR-1:0]         gpr_sel;
  logic [7:0]                 spc_sel;
  logic                       pc_wen, pc_inc, ir_wen, y_wen, z_wen;
  logic                       hi_wen, lo_wen, mar_wen, mdr_wen, mdr_read;
  logic [4:0]                 alu_op;
  logic                       alu_start;
  logic [DATA_W-1:0]          mem_din, inport_data, cimm_data;
  logic [DATA_W-1:0]          bus;
  logic [NUM_GPR*DATA_W-1:0]  gpr_q;
  logic [DATA_W-1:0]          pc_q, ir_q, y_q, zhi_q, zlo_q, hi_q, lo_q, mar_q, mdr_q;
  logic                       alu_busy, alu_done, div0, bus_conflict;

  modport master (
    output gpr_wen, gpr_sel, spc_sel, pc_wen, pc_inc, ir_wen, y_wen, z_wen,
           hi_wen, lo_wen, mar_wen, mdr_wen, mdr_read, alu_op, alu_start,
           mem_din, inport_data, cimm_data,
    input  bus, gpr_q, pc_q, ir_q, y_q, zhi_q, zlo_q, hi_q, lo_q, mar_q, mdr_q,
           alu_busy, alu_done, div0, bus_conflict
  );

  modport slave (
    input  gpr_wen, gpr_sel, spc_sel, pc_wen, pc_inc, ir_wen, y_wen, z_wen,
           hi_wen, lo_wen, mar_wen, mdr_wen, mdr_read, alu_op, alu_start,
           mem_din, inport_data, cimm_data,
    output bus, gpr_q, pc_q, ir_q, y_q, zhi_q, zlo_q, hi_q, lo_q, mar_q, mdr_q,
           alu_busy, alu_done, div0, bus_conflict
  );
endinterface

// File: rtl/param_datapath_alu_iter.sv
// Iterative signed MUL (shift-add) / DIV (restoring) engine, one step per cycle,
// DATA_W steps per operation; o_fin flags the cycle whose edge writes Z.
module alu_iter
  import dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_start,
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div0,
  output logic              o_fin,
  output logic [DATA_W-1:0] o_res_hi,
  output logic [DATA_W-1:0] o_res_lo
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  alu_state_t        r_state, w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic              r_div, r_neg_q, r_neg_r, r_dz, r_done, r_div0;
  logic [DATA_W-1:0] r_a, r_b, r_hi, r_lo;
  logic              w_accept, w_fin;
  logic [DATA_W-1:0] w_ma, w_mb, w_hi_nx, w_lo_nx;
  logic [DATA_W:0]   w_sum, w_trial;
  logic [2*DATA_W-1:0] w_prod;

  assign w_ma = i_a[DATA_W-1] ? -i_a : i_a;
  assign w_mb = i_b[DATA_W-1] ? -i_b : i_b;

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_fin      = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_accept   = 1'b1;
        w_state_nx = ST_BUSY;
      end
      ST_BUSY: if (r_cnt == LAST) begin
        w_fin      = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // r_hi/r_lo hold {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_trial = {r_hi, r_lo[DATA_W-1]} - {1'b0, r_b};
    if (r_div) begin
      if (!w_trial[DATA_W]) begin
        w_hi_nx = w_trial[DATA_W-1:0];
        w_lo_nx = {r_lo[DATA_W-2:0], 1'b1};
      end else begin
        w_hi_nx = {r_hi[DATA_W-2:0], r_lo[DATA_W-1]};
        w_lo_nx = {r_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_hi_nx = w_sum[DATA_W:1];
      w_lo_nx = {w_sum[0], r_lo[DATA_W-1:1]};
    end
  end

  always_comb begin
    w_prod   = {w_hi_nx, w_lo_nx};
    o_res_hi = '0;
    o_res_lo = '0;
    if (!r_div) begin
      if (r_neg_q) w_prod = -w_prod;
      {o_res_hi, o_res_lo} = w_prod;
    end else if (r_dz) begin
      o_res_hi = r_a;
      o_res_lo = '1;
    end else begin
      o_res_lo = r_neg_q ? -w_lo_nx : w_lo_nx;
      o_res_hi = r_neg_r ? -w_hi_nx : w_hi_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_fin;
      r_div0  <= w_fin && r_div && r_dz;
      if (w_accept) begin
        r_cnt   <= '0;
        r_div   <= i_is_div;
        r_neg_q <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
        r_neg_r <= i_a[DATA_W-1];
        r_dz    <= (i_b == '0);
        r_a     <= i_a;
        r_b     <= w_mb;
        r_hi    <= '0;
        r_lo    <= w_ma;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt + CW'(1);
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
      end
    end
  end

  assign o_busy = (r_state == ST_BUSY);
  assign o_done = r_done;
  assign o_div0 = r_div0;
  assign o_fin  = w_fin;

endmodule

// File: rtl/param_datapath.sv
// Single-bus datapath: GPR file, special registers, priority bus resolver with
// sticky contention flag, single-cycle ALU and the iterative MUL/DIV engine.
module param_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 16,
  parameter int R0_ZERO = 0
) (
  input logic             clk,
  input logic             clr,
  param_datapath_if.slave dp
);
  localparam int SW = NUM_GPR + 8;
  localparam logic [DATA_W-1:0] W_VEC = DATA_W'(DATA_W);

  logic [DATA_W-1:0] r_gpr [NUM_GPR];
  logic [DATA_W-1:0] r_pc, r_ir, r_y, r_zhi, r_zlo, r_hi, r_lo, r_mar, r_mdr;
  logic              r_conflict;

  logic [DATA_W-1:0] w_bus, w_sh, w_alu_lo, w_alu_hi, w_iter_hi, w_iter_lo;
  logic [DATA_W-1:0] w_spc_src [8];
  logic [SW-1:0]     w_sel_all;
  logic              w_hit, w_multi, w_sext, w_iter_fin, w_iter_busy;

  always_comb begin
    w_spc_src[SPC_PC]   = r_pc;
    w_spc_src[SPC_HI]   = r_hi;
    w_spc_src[SPC_LO]   = r_lo;
    w_spc_src[SPC_ZHI]  = r_zhi;
    w_spc_src[SPC_ZLO]  = r_zlo;
    w_spc_src[SPC_MDR]  = r_mdr;
    w_spc_src[SPC_IN]   = dp.inport_data;
    w_spc_src[SPC_CIMM] = dp.cimm_data;
  end

  // A zero-forced GPR0 still claims the bus when selected, so it masks lower-priority sources
  always_comb begin
    w_bus = '0;
    w_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_GPR; i++) begin
      if (!w_hit && dp.gpr_sel[i]) begin
        w_bus = (R0_ZERO != 0 && i == 0) ? '0 : r_gpr[i];
        w_hit = 1'b1;
      end
    end
    for (int unsigned j = 0; j < 8; j++) begin
      if (!w_hit && dp.spc_sel[j]) begin
        w_bus = w_spc_src[j];
        w_hit = 1'b1;
      end
    end
  end

  assign w_sel_all = {dp.spc_sel, dp.gpr_sel};
  assign w_multi   = |(w_sel_all & (w_sel_all - SW'(1)));

  assign w_sh = w_bus % W_VEC;

  always_comb begin
    w_alu_lo = '0;
    w_sext   = 1'b0;
    case (dp.alu_op)
      OP_ADD:  begin w_alu_lo = r_y + w_bus; w_sext = 1'b1; end
      OP_SUB:  begin w_alu_lo = r_y - w_bus; w_sext = 1'b1; end
      OP_AND:  w_alu_lo = r_y & w_bus;
      OP_OR:   w_alu_lo = r_y | w_bus;
      OP_SHR:  w_alu_lo = r_y >> w_sh;
      OP_SHRA: w_alu_lo = $signed(r_y) >>> w_sh;
      OP_SHL:  w_alu_lo = r_y << w_sh;
      OP_ROR:  w_alu_lo = (r_y >> w_sh) | (r_y << (W_VEC - w_sh));
      OP_ROL:  w_alu_lo = (r_y << w_sh) | (r_y >> (W_VEC - w_sh));
      OP_NEG:  begin w_alu_lo = -w_bus; w_sext = 1'b1; end
      OP_NOT:  w_alu_lo = ~w_bus;
      default: w_alu_lo = '0;
    endcase
    w_alu_hi = w_sext ? {DATA_W{w_alu_lo[DATA_W-1]}} : '0;
  end

  alu_iter #(.DATA_W(DATA_W)) u_alu_iter (
    .clk      (clk),
    .clr      (clr),
    .i_start  (dp.alu_start && is_iter_op(dp.alu_op)),
    .i_is_div (dp.alu_op == OP_DIV),
    .i_a      (r_y),
    .i_b      (w_bus),
    .o_busy   (w_iter_busy),
    .o_done   (dp.alu_done),
    .o_div0   (dp.div0),
    .o_fin    (w_iter_fin),
    .o_res_hi (w_iter_hi),
    .o_res_lo (w_iter_lo)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
      r_pc       <= '0;
      r_ir       <= '0;
      r_y        <= '0;
      r_zhi      <= '0;
      r_zlo      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mar      <= '0;
      r_mdr      <= '0;
      r_conflict <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_GPR; i++) begin
        if (dp.gpr_wen[i] && !(R0_ZERO != 0 && i == 0)) r_gpr[i] <= w_bus;
      end
      if (dp.pc_wen)      r_pc <= w_bus;
      else if (dp.pc_inc) r_pc <= r_pc + DATA_W'(1);
      if (dp.ir_wen)  r_ir  <= w_bus;
      if (dp.y_wen)   r_y   <= w_bus;
      if (dp.hi_wen)  r_hi  <= w_bus;
      if (dp.lo_wen)  r_lo  <= w_bus;
      if (dp.mar_wen) r_mar <= w_bus;
      if (dp.mdr_wen) r_mdr <= dp.mdr_read ? dp.mem_din : w_bus;
      if (w_iter_fin) begin
        r_zhi <= w_iter_hi;
        r_zlo <= w_iter_lo;
      end else if (dp.z_wen && !w_iter_busy) begin
        r_zhi <= w_alu_hi;
        r_zlo <= w_alu_lo;
      end
      if (w_multi) r_conflict <= 1'b1;
    end
  end

  always_comb begin
    dp.gpr_q = '0;
    for (int unsigned i = 0; i < NUM_GPR; i++) dp.gpr_q[i*DATA_W +: DATA_W] = r_gpr[i];
  end

  assign dp.bus          = w_bus;
  assign dp.pc_q         = r_pc;
  assign dp.ir_q         = r_ir;
  assign dp.y_q          = r_y;
  assign dp.zhi_q        = r_zhi;
  assign dp.zlo_q        = r_zlo;
  assign dp.hi_q         = r_hi;
  assign dp.lo_q         = r_lo;
  assign dp.mar_q        = r_mar;
  assign dp.mdr_q        = r_mdr;
  assign dp.alu_busy     = w_iter_busy;
  assign dp.bus_conflict = r_conflict;

endmodule

// File: tb/tb_param_datapath.sv
// Scoreboard bench for param_datapath: stimulus queues cycle-stamped and
// MUL/DIV expectations, a negedge monitor pops and compares them.
module tb_param_datapath;
  import dp_pkg::*;

  localparam int W  = 32;
  localparam int NG = 16;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  param_datapath_if #(.DATA_W(W), .NUM_GPR(NG)) dpif ();

  param_datapath #(.DATA_W(W), .NUM_GPR(NG), .R0_ZERO(1)) u_dut (
    .clk (clk),
    .clr (clr),
    .dp  (dpif.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  localparam int S_BUS = 0, S_ZLO = 1, S_ZHI = 2, S_GPR = 3, S_PC = 4,
                 S_Y = 5, S_BUSY = 6, S_CONF = 7;

  typedef struct {
    string          name;
    int             cyc;
    int             sig;
    int             idx;
    logic [W-1:0]   exp;
  } chk_t;

  typedef struct {
    string          name;
    int             issue;
    logic [W-1:0]   zhi;
    logic [W-1:0]   zlo;
    logic           dz;
  } iter_t;

  chk_t  q_chk[$];
  iter_t q_iter[$];

  function automatic logic [W-1:0] obs(input int sig, input int idx);
    case (sig)
      S_BUS:   return dpif.bus;
      S_ZLO:   return dpif.zlo_q;
      S_ZHI:   return dpif.zhi_q;
      S_GPR:   return dpif.gpr_q[idx*W +: W];
      S_PC:    return dpif.pc_q;
      S_Y:     return dpif.y_q;
      S_BUSY:  return W'(dpif.alu_busy);
      S_CONF:  return W'(dpif.bus_conflict);
      default: return 'x;
    endcase
  endfunction

  task automatic expect_at(input string name, input int d, input int sig,
                           input int idx, input logic [W-1:0] e);
    chk_t c;
    c.name = name; c.cyc = cyc + d; c.sig = sig; c.idx = idx; c.exp = e;
    q_chk.push_back(c);
  endtask

  task automatic expect_iter(input string name, input logic [W-1:0] zhi,
                             input logic [W-1:0] zlo, input logic dz);
    iter_t it;
    it.name = name; it.issue = cyc; it.zhi = zhi; it.zlo = zlo; it.dz = dz;
    q_iter.push_back(it);
  endtask

  int run = 0;
  always @(negedge clk) begin
    int i;
    logic [W-1:0] got;
    iter_t it;
    i = 0;
    while (i < q_chk.size()) begin
      if (q_chk[i].cyc <= cyc) begin
        checks++;
        got = obs(q_chk[i].sig, q_chk[i].idx);
        if (q_chk[i].cyc < cyc || got !== q_chk[i].exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", q_chk[i].name, got, q_chk[i].exp, cyc);
        end
        q_chk.delete(i);
      end else begin
        i++;
      end
    end
    if (dpif.alu_done) begin
      checks++;
      if (q_iter.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got alu_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        it = q_iter.pop_front();
        if (dpif.zhi_q !== it.zhi) begin
          errors++;
          $display("FAIL %s_zhi: got %h expected %h", it.name, dpif.zhi_q, it.zhi);
        end
        checks++;
        if (dpif.zlo_q !== it.zlo) begin
          errors++;
          $display("FAIL %s_zlo: got %h expected %h", it.name, dpif.zlo_q, it.zlo);
        end
        checks++;
        if (dpif.div0 !== it.dz) begin
          errors++;
          $display("FAIL %s_div0: got %b expected %b", it.name, dpif.div0, it.dz);
        end
        checks++;
        if (cyc - it.issue != W + 1) begin
          errors++;
          $display("FAIL %s_latency: got %0d expected %0d", it.name, cyc - it.issue, W + 1);
        end
        checks++;
        if (run != W) begin
          errors++;
          $display("FAIL %s_busy_len: got %0d expected %0d", it.name, run, W);
        end
      end
    end else if (dpif.div0) begin
      checks++;
      errors++;
      $display("FAIL div0_without_done: got div0=1 expected 0 (cycle %0d)", cyc);
    end
    if (dpif.alu_busy) run++;
    else run = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    dpif.gpr_wen     = '0;
    dpif.gpr_sel     = '0;
    dpif.spc_sel     = '0;
    dpif.pc_wen      = 1'b0;
    dpif.pc_inc      = 1'b0;
    dpif.ir_wen      = 1'b0;
    dpif.y_wen       = 1'b0;
    dpif.z_wen       = 1'b0;
    dpif.hi_wen      = 1'b0;
    dpif.lo_wen      = 1'b0;
    dpif.mar_wen     = 1'b0;
    dpif.mdr_wen     = 1'b0;
    dpif.mdr_read    = 1'b0;
    dpif.alu_op      = OP_ADD;
    dpif.alu_start   = 1'b0;
    dpif.mem_din     = '0;
    dpif.inport_data = '0;
    dpif.cimm_data   = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!dpif.alu_done && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (!dpif.alu_done) begin
      errors++;
      $display("FAIL done_timeout: got no alu_done expected within 60 cycles");
    end
  endtask

  task automatic load_y(input logic [W-1:0] v);
    idle_in();
    dpif.cimm_data = v;
    dpif.spc_sel   = 8'h80;
    dpif.y_wen     = 1'b1;
    tick();
    idle_in();
  endtask

  task automatic start_iter(input logic [4:0] op, input logic [W-1:0] b);
    idle_in();
    dpif.cimm_data = b;
    dpif.spc_sel   = 8'h80;
    dpif.alu_op    = op;
    dpif.alu_start = 1'b1;
  endtask

  logic [4:0]   t_op [6] = '{OP_SUB, OP_SHL, OP_ROR, OP_AND, OP_NEG, OP_ROL};
  logic [W-1:0] t_b  [6] = '{32'h20, 32'd36, 32'd4, 32'h30, 32'd5, 32'd31};
  logic [W-1:0] t_lo [6] = '{32'hFFFF_FFF2, 32'h120, 32'h2000_0001, 32'h10, 32'hFFFF_FFFB, 32'h9};
  logic [W-1:0] t_hi [6] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};

  initial begin
    idle_in();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    expect_at("rst_zlo", 0, S_ZLO, 0, '0);
    expect_at("rst_pc", 0, S_PC, 0, '0);
    expect_at("rst_busy", 0, S_BUSY, 0, '0);
    expect_at("rst_conflict", 0, S_CONF, 0, '0);
    expect_at("rst_bus", 0, S_BUS, 0, '0);
    tick();

    // R3 <- 0x12, Y <- R3, Z <- Y + R3
    dpif.cimm_data  = 32'h12;
    dpif.spc_sel    = 8'h80;
    dpif.gpr_wen[3] = 1'b1;
    expect_at("cimm_bus", 0, S_BUS, 0, 32'h12);
    tick();
    idle_in();
    dpif.gpr_sel[3] = 1'b1;
    dpif.y_wen      = 1'b1;
    expect_at("r3_load", 0, S_GPR, 3, 32'h12);
    tick();
    idle_in();
    dpif.gpr_sel[3] = 1'b1;
    dpif.alu_op     = OP_ADD;
    dpif.z_wen      = 1'b1;
    expect_at("y_load", 0, S_Y, 0, 32'h12);
    expect_at("add_zlo", 1, S_ZLO, 0, 32'h24);
    expect_at("add_zhi", 1, S_ZHI, 0, 32'h0);
    tick();

    for (int k = 0; k < 6; k++) begin
      idle_in();
      dpif.cimm_data = t_b[k];
      dpif.spc_sel   = 8'h80;
      dpif.alu_op    = t_op[k];
      dpif.z_wen     = 1'b1;
      expect_at($sformatf("alu%0d_zlo", k), 1, S_ZLO, 0, t_lo[k]);
      expect_at($sformatf("alu%0d_zhi", k), 1, S_ZHI, 0, t_hi[k]);
      tick();
    end

    // MUL -3 * 7, with ignored start/z_wen while busy, then back-to-back DIV
    load_y(32'hFFFF_FFFD);
    start_iter(OP_MUL, 32'd7);
    expect_iter("mul", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    expect_at("mul_busy", 1, S_BUSY, 0, 32'h1);
    tick();
    idle_in();
    repeat (4) tick();
    start_iter(OP_MUL, 32'd7);
    dpif.z_wen = 1'b1;
    expect_at("busy_zwen_ignored", 1, S_ZLO, 0, 32'h9);
    tick();
    idle_in();
    wait_done();
    start_iter(OP_DIV, 32'd7);
    expect_iter("div_b2b", 32'hFFFF_FFFD, 32'h0, 1'b0);
    tick();
    idle_in();
    wait_done();

    load_y(32'd17);
    start_iter(OP_DIV, 32'hFFFF_FFFB);
    expect_iter("div", 32'd2, 32'hFFFF_FFFD, 1'b0);
    tick();
    idle_in();
    wait_done();
    start_iter(OP_DIV, 32'd0);
    expect_iter("div_zero", 32'd17, 32'hFFFF_FFFF, 1'b1);
    tick();
    idle_in();
    wait_done();
    tick();

    // bus contention: R2 and PC together
    dpif.cimm_data  = 32'h55;
    dpif.spc_sel    = 8'h80;
    dpif.gpr_wen[2] = 1'b1;
    tick();
    idle_in();
    expect_at("conf_before", 0, S_CONF, 0, 32'h0);
    dpif.gpr_sel[2] = 1'b1;
    dpif.spc_sel[0] = 1'b1;
    expect_at("conf_bus", 0, S_BUS, 0, 32'h55);
    expect_at("conf_set", 1, S_CONF, 0, 32'h1);
    tick();
    idle_in();
    expect_at("conf_held", 2, S_CONF, 0, 32'h1);
    tick();

    // GPR0 hardwired zero
    dpif.cimm_data  = 32'hAA;
    dpif.spc_sel    = 8'h80;
    dpif.gpr_wen[0] = 1'b1;
    tick();
    idle_in();
    expect_at("r0_write_ignored", 0, S_GPR, 0, 32'h0);
    dpif.gpr_sel[0] = 1'b1;
    dpif.gpr_sel[2] = 1'b1;
    expect_at("r0_priority", 0, S_BUS, 0, 32'h0);
    tick();

    // PC load beats increment
    idle_in();
    dpif.cimm_data = 32'h100;
    dpif.spc_sel   = 8'h80;
    dpif.pc_wen    = 1'b1;
    dpif.pc_inc    = 1'b1;
    expect_at("pc_wen_wins", 1, S_PC, 0, 32'h100);
    tick();
    idle_in();
    dpif.pc_inc = 1'b1;
    expect_at("pc_inc", 1, S_PC, 0, 32'h101);
    tick();

    // MDR from memory, then onto the bus
    idle_in();
    dpif.mem_din  = 32'hDEAD;
    dpif.mdr_wen  = 1'b1;
    dpif.mdr_read = 1'b1;
    tick();
    idle_in();
    dpif.spc_sel[SPC_MDR] = 1'b1;
    expect_at("mdr_bus", 0, S_BUS, 0, 32'hDEAD);
    tick();

    // clr in the middle of a MUL, then immediate restart
    start_iter(OP_MUL, 32'd3);
    tick();
    idle_in();
    repeat (9) tick();
    clr = 1'b1;
    expect_at("clr_busy", 1, S_BUSY, 0, 32'h0);
    expect_at("clr_zlo", 1, S_ZLO, 0, 32'h0);
    expect_at("clr_zhi", 1, S_ZHI, 0, 32'h0);
    expect_at("clr_conflict", 1, S_CONF, 0, 32'h0);
    tick();
    clr = 1'b0;
    start_iter(OP_MUL, 32'd3);
    expect_iter("mul_after_clr", 32'h0, 32'h0, 1'b0);
    expect_at("restart_busy", 1, S_BUSY, 0, 32'h1);
    tick();
    idle_in();
    wait_done();
    repeat (3) tick();

    checks++;
    if (q_chk.size() + q_iter.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d outstanding expectations expected 0", q_chk.size() + q_iter.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
